alu_pipe: RTL and testbench
===========================

# alu_pipe

Elastic two-stage pipelined add/subtract unit for the CORDIC vectoring datapath, generalising the combinational `ALU` to signed shift-and-add micro-rotation ops, status flags and valid/ready flow control. Stage 1 registers operands and applies an arithmetic right shift to B. Stage 2 performs the add or subtract and registers result and flags. The block sits between the CORDIC iteration controller and the x/y/z register files, sustaining one operation per cycle under downstream backpressure.

## Interface
- `WORD_LENGTH`, 16, operand/result width in bits, ≥ 4.
- `SHIFT_W`, `$clog2(WORD_LENGTH)`, width of the shift-amount port.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept this cycle.
- `ALU_operation`  in  2  00 A+B, 01 A−B, 10 A+(B>>>shamt), 11 A−(B>>>shamt).
- `A`  in  WORD_LENGTH  operand A, two's complement.
- `B`  in  WORD_LENGTH  operand B, two's complement.
- `shamt`  in  SHIFT_W  arithmetic shift amount; ignored for ops 00/01.
- `out_valid`  out  1  result presented.
- `out_ready`  in  1  consumer accepts result.
- `AlU_out`  out  WORD_LENGTH  result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative (MSB), carry-out, signed overflow.

## Operation
- Transfer on a port occurs on a rising edge with valid && ready both high.
- Stage 1 (S1) captures `ALU_operation[0]`, A, and B' on input transfer. B' = B for ops 00/01, and B>>>shamt (sign-filling) for ops 10/11.
- Stage 2 (S2) computes sum = A + (sub ? ~B' : B') + sub at WORD_LENGTH+1 bits.
- flag_c = sum[WORD_LENGTH]. For subtract this is the no-borrow indication: 1 when A ≥ B' unsigned.
- flag_v = (A[msb] == B'eff[msb]) && (result[msb] != A[msb]), where B'eff is the inverted operand when subtracting.
- flag_z and flag_n are derived from the final `AlU_out`, i.e. after saturation when saturation is compiled in.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
- S2 loads from S1 when s2_adv. s2_valid takes s1_valid on that edge.
- While a stage is stalled, its contents hold unchanged. Output data and flags are stable while out_valid && !out_ready.
- Results emerge in strict input order. No op is dropped or duplicated.
- Simultaneous S2 drain and S1 refill in the same cycle is legal and sustains full throughput.
- shamt ≥ WORD_LENGTH is impossible by width when WORD_LENGTH is a power of two. Otherwise the value saturates to a full sign fill.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 op/cycle.
- Capacity: 2 ops in flight. After 2 accepted ops with out_ready low, in_ready = 0.
- Reset (rst_n low at an edge):
  - s1_valid, s2_valid, out_valid = 0.
  - AlU_out = 0, all flags = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight ops. No result for them is ever presented.
- in_ready has a combinational path from out_ready. There is no other combinational input-to-output path.

## Configuration
- `ALU_SAT_EN` defined: on flag_v = 1, AlU_out clamps to 0x7FF…F when the true result is positive and to 0x800…0 when it is negative. flag_v still reports 1.
- `ALU_SAT_EN` undefined: AlU_out is the wrapped WORD_LENGTH-bit sum. Flags are computed identically.

## Test plan
- Adds/subs, WORD_LENGTH=16, out_ready=1:
  - 16+32 → 48, flags all 0.
  - 0xFFFF+1 → 0x0000, z=1, c=1, v=0.
  - 45−90 → 0xFFD3, n=1, c=0.
  - 20−20 → 0, z=1, c=1.
  - Each result appears exactly 2 cycles after its input.
- Shift op: A=100, B=0xFFC0 (−64), shamt=3, op 10 → 92. Same operands with op 11 → 108.
- Overflow: 0x7FFF+1 → 0x8000 with v=1, n=1 without `ALU_SAT_EN`; 0x7FFF with v=1, n=0 with it. 0x8000−1 → 0x7FFF wrapped, or 0x8000 saturated.
- Backpressure:
  - Stream 5 back-to-back ops with out_ready low for cycles 3–6.
  - in_ready drops after 2 accepts.
  - Outputs are held stable during the stall.
  - All 5 results arrive in order with no loss.
- Reset mid-stream: assert rst_n low with 2 ops in flight → next cycle out_valid=0, AlU_out=0, in_ready=1. A subsequent op 21+18 returns 39 after 2 cycles.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: elastic two-stage add/sub with arithmetic pre-shift of B.
// Define ALU_SAT_EN to clamp overflowed results to the signed limits.
module alu_pipe #(
   parameter int WORD_LENGTH = 16,
   parameter int SHIFT_W     = $clog2(WORD_LENGTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             ALU_operation,
   input  logic [WORD_LENGTH-1:0] A,
   input  logic [WORD_LENGTH-1:0] B,
   input  logic [SHIFT_W-1:0]     shamt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_LENGTH-1:0] AlU_out,
   output logic                   flag_z,
   output logic                   flag_n,
   output logic                   flag_c,
   output logic                   flag_v
);

   localparam int MSB = WORD_LENGTH - 1;

   logic             r_s1_valid;
   logic             r_s1_sub;
   logic [MSB:0]     r_s1_a;
   logic [MSB:0]     r_s1_b;
   logic             r_s2_valid;
   logic [MSB:0]     r_out;
   logic             r_z;
   logic             r_n;
   logic             r_c;
   logic             r_v;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic [MSB:0]     w_b_asr;
   logic [MSB:0]     w_b_sh;
   logic [MSB:0]     w_b_eff;
   logic [MSB+1:0]   w_sum;
   logic             w_v;
   logic [MSB:0]     w_res;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // Kept on its own so the shift stays signed; oversize amounts sign-fill
   assign w_b_asr = $signed(B) >>> shamt;
   assign w_b_sh  = ALU_operation[1] ? w_b_asr : B;

   assign w_b_eff = r_s1_sub ? ~r_s1_b : r_s1_b;
   assign w_sum   = {1'b0, r_s1_a}
                  + {1'b0, w_b_eff}
                  + {{WORD_LENGTH{1'b0}}, r_s1_sub};
   assign w_v     = (r_s1_a[MSB] == w_b_eff[MSB])
                 && (w_sum[MSB] != r_s1_a[MSB]);

`ifdef ALU_SAT_EN
   // On overflow the true sign is that of A
   always_comb begin
      w_res = w_sum[MSB:0];
      if (w_v) begin
         w_res = r_s1_a[MSB] ? {1'b1, {MSB{1'b0}}}
                             : {1'b0, {MSB{1'b1}}};
      end
   end
`else
   assign w_res = w_sum[MSB:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sub   <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s2_valid <= 1'b0;
         r_out      <= '0;
         r_z        <= 1'b0;
         r_n        <= 1'b0;
         r_c        <= 1'b0;
         r_v        <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_sub <= ALU_operation[0];
               r_s1_a   <= A;
               r_s1_b   <= w_b_sh;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out <= w_res;
               r_z   <= (w_res == '0);
               r_n   <= w_res[MSB];
               r_c   <= w_sum[MSB+1];
               r_v   <= w_v;
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign AlU_out   = r_out;
   assign flag_z    = r_z;
   assign flag_n    = r_n;
   assign flag_c    = r_c;
   assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe arithmetic, flags, flow control.
// Honours ALU_SAT_EN for the overflow expectations.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  ALU_operation = 2'b00;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [3:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] AlU_out;
   logic        flag_z, flag_n, flag_c, flag_v;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WORD_LENGTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .ALU_operation(ALU_operation),
      .A(A), .B(B), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .AlU_out(AlU_out),
      .flag_z(flag_z), .flag_n(flag_n),
      .flag_c(flag_c), .flag_v(flag_v)
   );

   // Stimulus only: presents one op and samples out_valid at +1 and +2 edges
   task automatic drive_op(
      input  logic [1:0]  op,
      input  logic [15:0] a,
      input  logic [15:0] b,
      input  logic [3:0]  sh,
      output logic        ir,
      output logic        v1,
      output logic        v2,
      output logic [15:0] res,
      output logic [3:0]  fl
   );
      ALU_operation = op; A = a; B = b; shamt = sh;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      ir = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      v1 = out_valid;
      @(posedge clk); #1;
      v2 = out_valid;
      res = AlU_out;
      fl = {flag_z, flag_n, flag_c, flag_v};
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_valid got %b want 0", out_valid);
      end
      n_cmp++;
      if (AlU_out !== 16'h0) begin
         n_bad++; $display("FAIL reset_out got %h want 0000", AlU_out);
      end
      n_cmp++;
      if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 0000",
                  {flag_z, flag_n, flag_c, flag_v});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready got %b want 1", in_ready);
      end
   endtask

   // vec: op, A, B, shamt, expected result, expected {z,n,c,v}
   task automatic run_vectors(
      input string       nm,
      input int          n,
      input logic [1:0]  ops [8],
      input logic [15:0] as [8],
      input logic [15:0] bs [8],
      input logic [3:0]  shs [8],
      input logic [15:0] exs [8],
      input logic [3:0]  efs [8]
   );
      logic ir, v1, v2;
      logic [15:0] res;
      logic [3:0] fl;
      for (int i = 0; i < n; i++) begin
         drive_op(ops[i], as[i], bs[i], shs[i], ir, v1, v2, res, fl);
         n_cmp++;
         if (ir !== 1'b1 || v1 !== 1'b0 || v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s[%0d]_timing got rdy/v1/v2=%b%b%b want 101",
                     nm, i, ir, v1, v2);
         end
         n_cmp++;
         if (res !== exs[i]) begin
            n_bad++;
            $display("FAIL %s[%0d]_result got %h want %h", nm, i, res, exs[i]);
         end
         n_cmp++;
         if (fl !== efs[i]) begin
            n_bad++;
            $display("FAIL %s[%0d]_flags got %b want %b", nm, i, fl, efs[i]);
         end
      end
   endtask

   task automatic test_add_sub();
      logic [1:0]  ops [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
      logic [15:0] as  [8] = '{16, 16'hFFFF, 45, 20, 0, 0, 0, 0};
      logic [15:0] bs  [8] = '{32, 1, 90, 20, 0, 0, 0, 0};
      logic [3:0]  shs [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
      logic [15:0] exs [8] = '{48, 16'h0000, 16'hFFD3, 0, 0, 0, 0, 0};
      logic [3:0]  efs [8] = '{4'b0000, 4'b1010, 4'b0100, 4'b1010,
                               0, 0, 0, 0};
      run_vectors("addsub", 4, ops, as, bs, shs, exs, efs);
   endtask

   task automatic test_shift();
      logic [1:0]  ops [8] = '{2, 3, 2, 0, 0, 0, 0, 0};
      logic [15:0] as  [8] = '{100, 100, 0, 0, 0, 0, 0, 0};
      logic [15:0] bs  [8] = '{16'hFFC0, 16'hFFC0, 16'h8000, 0, 0, 0, 0, 0};
      logic [3:0]  shs [8] = '{3, 3, 15, 0, 0, 0, 0, 0};
      logic [15:0] exs [8] = '{92, 108, 16'hFFFF, 0, 0, 0, 0, 0};
      logic [3:0]  efs [8] = '{4'b0010, 4'b0000, 4'b0100, 0, 0, 0, 0, 0};
      run_vectors("shift", 3, ops, as, bs, shs, exs, efs);
   endtask

   task automatic test_overflow();
      logic [1:0]  ops [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
      logic [15:0] as  [8] = '{16'h7FFF, 16'h8000, 0, 0, 0, 0, 0, 0};
      logic [15:0] bs  [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
      logic [3:0]  shs [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef ALU_SAT_EN
      logic [15:0] exs [8] = '{16'h7FFF, 16'h8000, 0, 0, 0, 0, 0, 0};
      logic [3:0]  efs [8] = '{4'b0001, 4'b0111, 0, 0, 0, 0, 0, 0};
`else
      logic [15:0] exs [8] = '{16'h8000, 16'h7FFF, 0, 0, 0, 0, 0, 0};
      logic [3:0]  efs [8] = '{4'b0101, 4'b0011, 0, 0, 0, 0, 0, 0};
`endif
      run_vectors("ovf", 2, ops, as, bs, shs, exs, efs);
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp [5] = '{101, 202, 303, 404, 505};
      int sent = 0;
      int got = 0;
      logic held = 1'b0;
      logic [15:0] hv = '0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         in_valid = (sent < 5);
         ALU_operation = 2'b00; shamt = '0;
         A = 16'(100 * (sent + 1));
         B = 16'(sent + 1);
         #1;
         if (held) begin
            n_cmp++;
            if (AlU_out !== hv) begin
               n_bad++;
               $display("FAIL bp_hold c=%0d got %h want %h", c, AlU_out, hv);
            end
         end
         if (c >= 3 && c <= 6) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL bp_ready c=%0d got %b want 0", c, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (AlU_out !== exp[got]) begin
               n_bad++;
               $display("FAIL bp_order[%0d] got %h want %h",
                        got, AlU_out, exp[got]);
            end
            got++;
         end
         held = out_valid && !out_ready;
         hv = AlU_out;
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (got !== 5 || sent !== 5) begin
         n_bad++;
         $display("FAIL bp_count got %0d/%0d want 5/5", got, sent);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_extra got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic ir, v1, v2;
      logic [15:0] res;
      logic [3:0] fl;
      int ghost = 0;
      out_ready = 1'b0; in_valid = 1'b1;
      ALU_operation = 2'b00; A = 1; B = 1; shamt = '0;
      @(posedge clk); #1;
      A = 2; B = 2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || AlU_out !== 16'h0) begin
         n_bad++;
         $display("FAIL rstmid_out got v=%b %h want v=0 0000",
                  out_valid, AlU_out);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_ready got %b want 1", in_ready);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (out_valid !== 1'b0) ghost++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (ghost !== 0) begin
         n_bad++; $display("FAIL rstmid_ghost got %0d want 0", ghost);
      end
      drive_op(2'b00, 21, 18, 0, ir, v1, v2, res, fl);
      n_cmp++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || res !== 16'd39 || fl !== 4'b0) begin
         n_bad++;
         $display("FAIL rstmid_op got v=%b%b %h %b want v=01 0027 0000",
                  v1, v2, res, fl);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
